// File: rtl/board_renderer.sv
// Pixel-colour stage behind the 640x480 VGA timing generator: paints the 4x4 2048 board
// with a 2-pixel-tick pipeline and swaps in new boards only at the start of vblank.
module board_renderer #(
  parameter int BOARD_X0 = 108,
  parameter int BOARD_Y0 = 28,
  parameter int TILE     = 96,
  parameter int GAP      = 8,
  parameter int V_ACTIVE = 480
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pixel_clk,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  input  logic [63:0] board_in,
  input  logic        upd_valid,
  output logic        upd_ready,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        frame_start
);

  localparam int PITCH = TILE + GAP;
  localparam int SPAN  = 4 * TILE + 5 * GAP;
  localparam logic [9:0] SWAP_LINE = 10'(V_ACTIVE);

  // Returns {in_span, in_tile, tile_index[1:0]} for one axis; constant compares only.
  function automatic logic [3:0] axis_decode(input logic [9:0] p, input int org);
    int v;
    logic [3:0] r;
    v = int'(p);
    r = '0;
    if (v >= org && v < org + SPAN) r[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (v >= org + GAP + k * PITCH && v < org + GAP + k * PITCH + TILE) begin
        r[2]   = 1'b1;
        r[1:0] = 2'(k);
      end
    end
    return r;
  endfunction

  function automatic logic [11:0] tile_colour(input logic [3:0] e);
    case (e)
      4'd0:    return 12'hCCB;
      4'd1:    return 12'hEED;
      4'd2:    return 12'hEEC;
      4'd3:    return 12'hFB7;
      4'd4:    return 12'hF96;
      4'd5:    return 12'hF75;
      4'd6:    return 12'hF53;
      4'd7:    return 12'hEC7;
      4'd8:    return 12'hEC6;
      4'd9:    return 12'hEC5;
      4'd10:   return 12'hEC3;
      4'd11:   return 12'hEC2;
      default: return 12'h333;
    endcase
  endfunction

  logic        pixel_clk_q;
  logic        pix_tick;
  logic        swap;
  logic [3:0]  dec_x, dec_y;

  logic        s1_in_board, s1_in_tile, s1_blank, s1_hs, s1_vs;
  logic [1:0]  s1_col, s1_row;
  logic [3:0]  cell_exp;
  logic [11:0] rgb_next;

  logic [63:0] active;
  logic [63:0] pending;
  logic        pending_full;

  assign pix_tick  = pixel_clk & ~pixel_clk_q;
  assign swap      = pix_tick && DrawX == 10'd0 && DrawY == SWAP_LINE;
  assign upd_ready = ~pending_full;

  always_comb begin
    dec_x    = axis_decode(DrawX, BOARD_X0);
    dec_y    = axis_decode(DrawY, BOARD_Y0);
    cell_exp = active[{s1_row, s1_col, 2'b00} +: 4];
    rgb_next = 12'h000;
    if (!s1_blank)         rgb_next = 12'h000;
    else if (!s1_in_board) rgb_next = 12'hFFE;
    else if (!s1_in_tile)  rgb_next = 12'hBBA;
    else                   rgb_next = tile_colour(cell_exp);
  end

  // Stage-1 syncs reset to the idle (high) level so no false sync pulse follows reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pixel_clk_q <= 1'b0;
      s1_in_board <= 1'b0;
      s1_in_tile  <= 1'b0;
      s1_col      <= 2'd0;
      s1_row      <= 2'd0;
      s1_blank    <= 1'b0;
      s1_hs       <= 1'b1;
      s1_vs       <= 1'b1;
      red         <= 4'd0;
      green       <= 4'd0;
      blue        <= 4'd0;
      hs_out      <= 1'b1;
      vs_out      <= 1'b1;
      blank_out   <= 1'b0;
    end else begin
      pixel_clk_q <= pixel_clk;
      if (pix_tick) begin
        s1_in_board <= dec_x[3] & dec_y[3];
        s1_in_tile  <= dec_x[2] & dec_y[2];
        s1_col      <= dec_x[1:0];
        s1_row      <= dec_y[1:0];
        s1_blank    <= blank_in;
        s1_hs       <= hs_in;
        s1_vs       <= vs_in;
        {red, green, blue} <= rgb_next;
        hs_out      <= s1_hs;
        vs_out      <= s1_vs;
        blank_out   <= s1_blank;
      end
    end
  end

  // Ready is low while full, so a transfer and a swap never land on the same edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= swap;
      if (upd_valid && !pending_full) begin
        pending      <= board_in;
        pending_full <= 1'b1;
      end else if (swap && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
    end
  end

endmodule
